// File: rtl/bus_owner_sequencer_pkg.sv
// Shared definitions for the bus ownership sequencer and the memory controller.
//   - state_e      : sequencer states
//   - bus_sel_t    : bundle of the registered bus-select / handshake outputs
//   - defaults for TURN_CYCLES and DRAIN_LIMIT
//   - BusMappedBase: address split between SRAM and the mapped region (memory controller)
//   - decode_sel() : output decode for a given state / turnaround target
package bus_owner_sequencer_pkg;

    typedef enum logic [2:0] {
        StBoot,
        StTurn,
        StRun,
        StDrain,
        StPaused
    } state_e;

    typedef struct packed {
        logic is_booted;
        logic is_paused;
        logic disable_drive;
        logic core_stall;
        logic jtag_grant;
    } bus_sel_t;

    localparam int unsigned DefaultTurnCycles = 1;
    localparam int unsigned DefaultDrainLimit = 64;

    // Addresses at or above this boundary are memory-mapped peripherals, not SRAM.
    localparam logic [15:0] BusMappedBase = 16'hC000;

    localparam bus_sel_t SelReset = '{
        is_booted:     1'b0,
        is_paused:     1'b0,
        disable_drive: 1'b0,
        core_stall:    1'b1,
        jtag_grant:    1'b0
    };

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // The mux select (is_paused) only changes while the drive is off: during TURN it already
    // reflects the owner being handed to.
    function automatic bus_sel_t decode_sel(input state_e st, input state_e tgt);
        bus_sel_t s;
        s = '{
            is_booted:     1'b1,
            is_paused:     1'b0,
            disable_drive: 1'b0,
            core_stall:    1'b1,
            jtag_grant:    1'b0
        };
        case (st)
            StBoot:   s.is_booted = 1'b0;
            StTurn: begin
                s.is_paused     = (tgt == StPaused);
                s.disable_drive = 1'b1;
            end
            StRun:    s.core_stall = 1'b0;
            StDrain:  s.core_stall = 1'b1;
            StPaused: begin
                s.is_paused  = 1'b1;
                s.jtag_grant = 1'b1;
            end
            default:  s = SelReset;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bus_owner_sequencer_if.sv
// Handshake / bus-select bundle between the sequencer and its neighbours.
//   Inputs to the sequencer : i_bootDone, i_pauseReq, i_coreIdle, i_jtagIdle
//   Outputs of the sequencer: o_isBooted, o_isPaused, o_disableDrive, o_coreStall,
//                             o_jtagGrant, o_drainTimeout
//   modport slave  : used by the sequencer
//   modport master : used by the surrounding logic (boot, JTAG, core, testbench)
interface bus_owner_sequencer_if;

    logic i_bootDone;
    logic i_pauseReq;
    logic i_coreIdle;
    logic i_jtagIdle;

    logic o_isBooted;
    logic o_isPaused;
    logic o_disableDrive;
    logic o_coreStall;
    logic o_jtagGrant;
    logic o_drainTimeout;

    modport slave (
        input  i_bootDone,
        input  i_pauseReq,
        input  i_coreIdle,
        input  i_jtagIdle,
        output o_isBooted,
        output o_isPaused,
        output o_disableDrive,
        output o_coreStall,
        output o_jtagGrant,
        output o_drainTimeout
    );

    modport master (
        output i_bootDone,
        output i_pauseReq,
        output i_coreIdle,
        output i_jtagIdle,
        input  o_isBooted,
        input  o_isPaused,
        input  o_disableDrive,
        input  o_coreStall,
        input  o_jtagGrant,
        input  o_drainTimeout
    );

endinterface

// File: rtl/bus_owner_sequencer_turn_counter.sv
// Loadable saturating down-counter shared by the turnaround window and the drain watchdog.
//   clk_i, rst_ni : clock, asynchronous active-low reset (count resets to 0)
//   load_i        : load load_val_i (takes priority over dec_i)
//   load_val_i    : value to load
//   dec_i         : decrement by one, holding at zero
//   done_o        : count is zero
module bus_owner_sequencer_turn_counter #(
    parameter int unsigned Width = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             dec_i,
    output logic             done_o
);

    logic [Width-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - Width'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/bus_owner_sequencer.sv
// Decides which circuit owns the shared memory bus (boot block, core, JTAG) and drives the
// memory controller selects. Every owner change passes through TURN, where the bus controls
// are tristated for TURN_CYCLES cycles. A pause request first stalls and drains the core.
//   i_clk, i_rstn : clock, asynchronous active-low reset
//   sel_if        : slave side of bus_owner_sequencer_if (requests in, selects out)
// Optional feature: define BUS_OWNER_WATCHDOG_EN to force a pause after DRAIN_LIMIT cycles
// of a busy core in DRAIN and raise the sticky o_drainTimeout flag. Without it, DRAIN waits
// indefinitely and o_drainTimeout stays 0.
module bus_owner_sequencer
    import bus_owner_sequencer_pkg::*;
#(
    parameter int unsigned TURN_CYCLES = DefaultTurnCycles,
    parameter int unsigned DRAIN_LIMIT = DefaultDrainLimit
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    bus_owner_sequencer_if.slave sel_if
);

    localparam int unsigned CntW = $clog2(max_u(TURN_CYCLES, DRAIN_LIMIT) + 1);
    // The counter is checked for zero before decrementing, so loading N-1 yields N cycles.
    localparam logic [CntW-1:0] TurnLoad = CntW'(TURN_CYCLES - 1);
`ifdef BUS_OWNER_WATCHDOG_EN
    localparam logic [CntW-1:0] DrainLoad = CntW'(DRAIN_LIMIT - 1);
`endif

    state_e    state_d, state_q;
    state_e    target_d, target_q;
    logic      timeout_d, timeout_q;
    bus_sel_t  out_d, out_q;

    logic            cnt_load;
    logic [CntW-1:0] cnt_load_val;
    logic            cnt_dec;
    logic            cnt_done;

    bus_owner_sequencer_turn_counter #(
        .Width (CntW)
    ) u_turn_counter (
        .clk_i      (i_clk),
        .rst_ni     (i_rstn),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .done_o     (cnt_done)
    );

    always_comb begin
        state_d      = state_q;
        target_d     = target_q;
        timeout_d    = timeout_q;
        cnt_load     = 1'b0;
        cnt_load_val = TurnLoad;
        cnt_dec      = 1'b0;

        unique case (state_q)
            // Pause requests are ignored here; being level, they are picked up from RUN.
            StBoot: begin
                if (sel_if.i_bootDone) begin
                    state_d  = StTurn;
                    target_d = StRun;
                    cnt_load = 1'b1;
                end
            end
            StTurn: begin
                if (cnt_done) begin
                    state_d = target_q;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            StRun: begin
                if (sel_if.i_pauseReq) begin
                    state_d = StDrain;
`ifdef BUS_OWNER_WATCHDOG_EN
                    cnt_load     = 1'b1;
                    cnt_load_val = DrainLoad;
`endif
                end
            end
            StDrain: begin
                // Abort wins over both core-idle and watchdog expiry.
                if (!sel_if.i_pauseReq) begin
                    state_d = StRun;
                end else if (sel_if.i_coreIdle) begin
                    state_d  = StTurn;
                    target_d = StPaused;
                    cnt_load = 1'b1;
                end
`ifdef BUS_OWNER_WATCHDOG_EN
                else if (cnt_done) begin
                    state_d   = StTurn;
                    target_d  = StPaused;
                    timeout_d = 1'b1;
                    cnt_load  = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
`endif
            end
            StPaused: begin
                if (!sel_if.i_pauseReq && sel_if.i_jtagIdle) begin
                    state_d  = StTurn;
                    target_d = StRun;
                    cnt_load = 1'b1;
                end
            end
            default: begin
                state_d  = StBoot;
                target_d = StRun;
            end
        endcase

        if ((state_d == StRun) && (state_q != StRun)) begin
            timeout_d = 1'b0;
        end
`ifndef BUS_OWNER_WATCHDOG_EN
        timeout_d = 1'b0;
`endif

        // Outputs are registered: decode from the state being entered.
        out_d = decode_sel(state_d, target_d);
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q   <= StBoot;
            target_q  <= StRun;
            timeout_q <= 1'b0;
            out_q     <= SelReset;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            timeout_q <= timeout_d;
            out_q     <= out_d;
        end
    end

    assign sel_if.o_isBooted     = out_q.is_booted;
    assign sel_if.o_isPaused     = out_q.is_paused;
    assign sel_if.o_disableDrive = out_q.disable_drive;
    assign sel_if.o_coreStall    = out_q.core_stall;
    assign sel_if.o_jtagGrant    = out_q.jtag_grant;
    assign sel_if.o_drainTimeout = timeout_q;

endmodule

// File: tb/tb_bus_owner_sequencer.sv
// Scoreboard bench for bus_owner_sequencer. A driver applies inputs on the falling edge, steps
// an owner-level reference model and queues the expected outputs; a monitor pops one entry
// per rising edge and compares. Output vector order:
// {isBooted, isPaused, disableDrive, coreStall, jtagGrant, drainTimeout}.
module tb_bus_owner_sequencer;

    localparam int unsigned TC = 2;
    localparam int unsigned DL = 4;
`ifdef BUS_OWNER_WATCHDOG_EN
    localparam bit WdEn = 1'b1;
`else
    localparam bit WdEn = 1'b0;
`endif

    localparam int OwnBoot = 0;
    localparam int OwnCore = 1;
    localparam int OwnJtag = 2;

    logic clk;
    logic rstn;

    bus_owner_sequencer_if sif ();

    bus_owner_sequencer #(
        .TURN_CYCLES (TC),
        .DRAIN_LIMIT (DL)
    ) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .sel_if (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [5:0] exp_q[$];

    // Reference model: who owns the bus, whether a handover is in progress and how many
    // turnaround cycles remain, whether the core is being drained.
    int owner;
    int next_owner;
    int turn_left;
    int drain_cnt;
    bit draining;
    bit tmo;

    function automatic void model_reset();
        owner      = OwnBoot;
        next_owner = OwnCore;
        turn_left  = 0;
        drain_cnt  = 0;
        draining   = 1'b0;
        tmo        = 1'b0;
    endfunction

    function automatic void start_turn(input int to);
        next_owner = to;
        turn_left  = TC;
        draining   = 1'b0;
    endfunction

    function automatic void model_step(input bit b, input bit p, input bit ci, input bit ji);
        if (turn_left > 0) begin
            turn_left--;
            if (turn_left == 0) begin
                owner = next_owner;
                if (owner == OwnCore) tmo = 1'b0;
            end
        end else if (owner == OwnBoot) begin
            if (b) start_turn(OwnCore);
        end else if (owner == OwnCore) begin
            if (!draining) begin
                if (p) begin
                    draining  = 1'b1;
                    drain_cnt = 0;
                end
            end else if (!p) begin
                draining = 1'b0;
                tmo      = 1'b0;
            end else if (ci) begin
                start_turn(OwnJtag);
            end else if (WdEn) begin
                drain_cnt++;
                if (drain_cnt >= int'(DL)) begin
                    tmo = 1'b1;
                    start_turn(OwnJtag);
                end
            end
        end else begin
            if (!p && ji) start_turn(OwnCore);
        end
    endfunction

    function automatic logic [5:0] model_out();
        if (turn_left > 0) return {1'b1, next_owner == OwnJtag, 1'b1, 1'b1, 1'b0, tmo};
        if (owner == OwnBoot) return {5'b00010, tmo};
        if (owner == OwnCore) return {1'b1, 1'b0, 1'b0, draining, 1'b0, tmo};
        return {5'b11011, tmo};
    endfunction

    function automatic logic [5:0] dut_out();
        return {sif.o_isBooted, sif.o_isPaused, sif.o_disableDrive, sif.o_coreStall,
                sif.o_jtagGrant, sif.o_drainTimeout};
    endfunction

    task automatic drive(input bit b, input bit p, input bit ci, input bit ji);
        sif.i_bootDone = b;
        sif.i_pauseReq = p;
        sif.i_coreIdle = ci;
        sif.i_jtagIdle = ji;
        model_step(b, p, ci, ji);
        exp_q.push_back(model_out());
    endtask

    task automatic step(input bit b, input bit p, input bit ci, input bit ji, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            drive(b, p, ci, ji);
        end
    endtask

    // Asynchronous reset between edges; outputs must take reset values without a clock.
    task automatic do_reset();
        logic [5:0] act;
        @(negedge clk);
        #2;
        sif.i_bootDone = 1'b0;
        sif.i_pauseReq = 1'b0;
        sif.i_coreIdle = 1'b0;
        sif.i_jtagIdle = 1'b0;
        rstn = 1'b0;
        #1;
        act = dut_out();
        checks++;
        if (act !== 6'b000100) begin
            errors++;
            $display("FAIL async_reset t=%0t got %b want %b", $time, act, 6'b000100);
        end
        exp_q.delete();
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor
    initial begin
        logic [5:0] exp_v;
        logic [5:0] act_v;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                act_v = dut_out();
                checks++;
                if (act_v !== exp_v) begin
                    errors++;
                    $display("FAIL outputs t=%0t got %b want %b", $time, act_v, exp_v);
                end
            end
        end
    end

    // Driver
    initial begin
        bit b, p, ci, ji;
        rstn = 1'b0;
        sif.i_bootDone = 1'b0;
        sif.i_pauseReq = 1'b0;
        sif.i_coreIdle = 1'b0;
        sif.i_jtagIdle = 1'b0;
        model_reset();

        do_reset();
        step(0, 0, 0, 0, 20);     // stays in boot
        step(1, 0, 0, 0, 6);      // handover to the core
        step(1, 1, 0, 0, 5);      // drain with busy core
        step(1, 1, 1, 0, 5);      // core idle -> pause
        step(1, 0, 0, 0, 3);      // JTAG busy keeps it paused
        step(1, 0, 0, 1, 5);      // resume
        step(1, 1, 0, 0, 2);      // drain then abort
        step(1, 0, 0, 0, 3);
        step(1, 1, 1, 1, 6);      // pause again
        step(1, 0, 0, 1, 1);      // enter turnaround ...
        do_reset();               // ... and reset in the middle of it

        b = 1'b0;
        p = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
                b = 1'b0;
                p = 1'b0;
            end else begin
                if ($urandom_range(0, 9) == 0) b = ~b;
                if ($urandom_range(0, 7) == 0) p = ~p;
                ci = ($urandom_range(0, 3) == 0);
                ji = ($urandom_range(0, 1) == 0);
                step(b, p, ci, ji, 1);
            end
        end

        step(1, 0, 1, 1, 2);
        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_owner_sequencer.md
# bus_owner_sequencer

Sequencer that decides which circuit owns the shared memory bus (Boot Block, Processor Core, or JTAG Port) and drives the memory controller's `i_isBooted`, `i_isPaused` and `i_disableDrive` selects. Every ownership change goes through a tristate turnaround window, so two drivers never contend on the bus. On a pause request, the core is stalled and drained before JTAG is granted. The block sits in the MCU top level, between the boot circuit, the JTAG port, the core pipeline and the memory controller mux.

## Interface
Parameters:
- `TURN_CYCLES`, default 1: dead cycles with the bus undriven at each owner change. Must be ≥1.
- `DRAIN_LIMIT`, default 64: cycles allowed for the core to go idle before a forced pause. Used only with the watchdog.

Ports:
- `i_clk` in 1: system clock. The block has one clock.
- `i_rstn` in 1: reset, asynchronous and active-low.
- `i_bootDone` in 1: boot block has finished copying the image to SRAM. Level input.
- `i_pauseReq` in 1: JTAG wants the MCU paused. Level input; high means stay paused.
- `i_coreIdle` in 1: core has no memory access in flight.
- `i_jtagIdle` in 1: JTAG has no memory access in flight.
- `o_isBooted` out 1: select to the memory controller, 0 = boot owns the bus.
- `o_isPaused` out 1: select to the memory controller, 1 = JTAG owns the bus.
- `o_disableDrive` out 1: tristates the memory bus controls.
- `o_coreStall` out 1: core must not issue new memory accesses.
- `o_jtagGrant` out 1: JTAG may issue memory accesses.
- `o_drainTimeout` out 1: sticky flag, the core was force-paused.

## Operation
- Moore FSM. All outputs are decoded from the registered state and flags.
- States: BOOT, TURN, RUN, DRAIN, PAUSED. TURN holds a registered target, RUN or PAUSED.
- Reset state is BOOT. Reset values: `o_isBooted`=0, `o_isPaused`=0, `o_disableDrive`=0, `o_coreStall`=1, `o_jtagGrant`=0, `o_drainTimeout`=0. Turnaround counter resets to 0.
- BOOT: boot owns the bus.
  - When `i_bootDone`=1, go to TURN with target RUN.
  - `i_pauseReq` is ignored in BOOT. Because it is a level input, a request held through boot takes effect from RUN.
- TURN: `o_disableDrive`=1, `o_coreStall`=1, `o_jtagGrant`=0.
  - `o_isBooted`=1 on every TURN cycle.
  - `o_isPaused` equals (target==PAUSED). The mux select therefore switches only while the drive is off.
  - Counter counts TURN_CYCLES cycles, then go to the target state.
- RUN: `o_isBooted`=1, `o_isPaused`=0, `o_coreStall`=0, `o_disableDrive`=0.
  - When `i_pauseReq`=1, go to DRAIN.
  - Entering RUN clears `o_drainTimeout`.
- DRAIN: same bus outputs as RUN, but `o_coreStall`=1.
  - `i_pauseReq`=0: return to RUN. This abort takes priority; no bus switch occurs.
  - Otherwise, when `i_coreIdle`=1, go to TURN with target PAUSED.
- PAUSED: `o_isBooted`=1, `o_isPaused`=1, `o_jtagGrant`=1, `o_coreStall`=1, `o_disableDrive`=0.
  - When `i_pauseReq`=0 and `i_jtagIdle`=1, go to TURN with target RUN.
  - If `i_pauseReq` drops while JTAG is busy, the block stays in PAUSED until `i_jtagIdle`=1.
- Requests arriving during TURN are not acted on until the target state is reached. Level semantics make this safe.
- Counter width is clog2(max(TURN_CYCLES, DRAIN_LIMIT)+1). The counter saturates and never wraps.

## Timing
- Pause request sampled high in RUN at cycle n, with the core idle and TURN_CYCLES=1:
  - DRAIN at n+1.
  - TURN at n+2.
  - PAUSED, with `o_jtagGrant`=1, at n+3.
- Resume: `i_pauseReq` low in PAUSED with JTAG idle at cycle n gives TURN at n+1 and RUN at n+2.
- Boot handover: `i_bootDone` at cycle n gives TURN at n+1 and RUN at n+1+TURN_CYCLES.
- `o_disableDrive` is high for exactly TURN_CYCLES consecutive cycles per handover and is never high outside TURN.
- Asynchronous reset in any state, including mid-TURN, returns to BOOT immediately with all reset values.

## Configuration
- `BUS_OWNER_WATCHDOG_EN` defined:
  - DRAIN counts cycles with `i_coreIdle`=0.
  - On reaching DRAIN_LIMIT, go to TURN with target PAUSED and set `o_drainTimeout`=1.
  - An abort (`i_pauseReq`=0) still takes priority over expiry in the same cycle.
- Not defined: DRAIN waits indefinitely and `o_drainTimeout` is tied to 0.

## Structure
- Shared package contains:
  - The state enum (BOOT, TURN, RUN, DRAIN, PAUSED).
  - Default TURN_CYCLES and DRAIN_LIMIT constants.
  - The bus address split constant (0xC000 mapped boundary), reused by the memory controller.
- One sub-module, `turn_counter`: loadable saturating down-counter with a done flag, shared by TURN and the watchdog.

## Test plan
1. Reset with all inputs 0 → outputs 0,0,0,1,0,0. Stays in BOOT for 20 cycles with no bus changes.
2. `i_bootDone`=1 at cycle 5, TURN_CYCLES=2 → `o_disableDrive` high during cycles 6–7 with `o_isBooted`=1, then RUN at cycle 8 with `o_coreStall`=0.
3. In RUN, `i_pauseReq`=1 with `i_coreIdle` low for 5 cycles → stall held for 5 cycles, one turnaround with `o_isPaused`=1, then `o_jtagGrant`=1.
4. In DRAIN, drop `i_pauseReq` before the core is idle → back to RUN next cycle, `o_disableDrive` never asserted.
5. In PAUSED, `i_pauseReq`=0 with `i_jtagIdle`=0 for 3 cycles → remains PAUSED, then TURN → RUN.
6. With `BUS_OWNER_WATCHDOG_EN`, DRAIN_LIMIT=4, core never idle → forced TURN after 4 cycles, `o_drainTimeout`=1, cleared on the next RUN entry. Also assert `i_rstn` low mid-TURN → immediate reset values.
